// File: rtl/arith_ctrl_if.sv
// Bus between arith_ctrl and the MIX add/sub/mul/div units: start pulse,
// registered operands going out, unit result and overflow coming back.
interface arith_ctrl_if;
    logic        u_start;
    logic [1:0]  u_op;
    logic [30:0] u_in1;
    logic [30:0] u_in2;
    logic [60:0] u_dvd;
    logic [30:0] u_dvs;
    logic [30:0] u_hi;
    logic [30:0] u_lo;
    logic        u_ovf;

    modport master (
        output u_start, u_op, u_in1, u_in2, u_dvd, u_dvs,
        input  u_hi, u_lo, u_ovf
    );

    modport slave (
        input  u_start, u_op, u_in1, u_in2, u_dvd, u_dvs,
        output u_hi, u_lo, u_ovf
    );
endinterface

// File: rtl/arith_ctrl.sv
// MIX arithmetic sequencer: latches operands, launches a unit, waits its latency, writes back.
// Define ARITH_CTRL_FIELD_EN for L:R field extraction and fspec validation; otherwise V = mem.
module arith_ctrl #(
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 10,
    parameter int LAT_DIV = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [1:0]  op,
    input  logic [5:0]  fspec,
    input  logic [30:0] mem,
    input  logic [30:0] ra_in,
    input  logic [30:0] rx_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ovf_set,
    output logic        ra_we,
    output logic        rx_we,
    output logic [30:0] ra_out,
    output logic [30:0] rx_out,
    arith_ctrl_if.master ubus
);
    typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, WB = 2'd3} state_t;

    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_DIV  = 2'd3;
    localparam logic [7:0] CNT_ADD = 8'(LAT_ADD - 1);
    localparam logic [7:0] CNT_MUL = 8'(LAT_MUL - 1);
    localparam logic [7:0] CNT_DIV = 8'(LAT_DIV - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [30:0] v_s;
    logic        fvalid_s;

    // Bytes max(L,1)..R of m, right-justified; sign only taken when L=0.
    function automatic logic [30:0] field_v(input logic [30:0] m, input logic [5:0] f);
        logic [2:0]  l;
        logic [2:0]  r;
        logic [2:0]  lo;
        logic [2:0]  nb;
        logic [5:0]  sh;
        logic [5:0]  nbits;
        logic [29:0] mask;
        logic [29:0] mag;
        l     = f[5:3];
        r     = f[2:0];
        lo    = (l == 3'd0) ? 3'd1 : l;
        nb    = r - lo + 3'd1;
        sh    = 6'd6 * {3'd0, 3'd5 - r};
        nbits = 6'd6 * {3'd0, nb};
        mask  = (30'd1 << nbits) - 30'd1;
        if (r == 3'd0) begin
            mag = 30'd0;
        end else begin
            mag = (m[29:0] >> sh) & mask;
        end
        return {(l == 3'd0) ? m[30] : 1'b0, mag};
    endfunction

`ifdef ARITH_CTRL_FIELD_EN
    assign v_s      = field_v(mem, fspec);
    assign fvalid_s = (fspec[5:3] <= fspec[2:0]) && (fspec[2:0] <= 3'd5);
`else
    logic fspec_unused_s;
    assign fspec_unused_s = ^{fspec, field_v(mem, fspec)};
    assign v_s      = mem;
    assign fvalid_s = 1'b1;
`endif

    // Sequencer FSM; every output is a register updated on state transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            ovf_set      <= 1'b0;
            ra_we        <= 1'b0;
            rx_we        <= 1'b0;
            ra_out       <= 31'd0;
            rx_out       <= 31'd0;
            ubus.u_start <= 1'b0;
            ubus.u_op    <= 2'd0;
            ubus.u_in1   <= 31'd0;
            ubus.u_in2   <= 31'd0;
            ubus.u_dvd   <= 61'd0;
            ubus.u_dvs   <= 31'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (go) begin
                        busy       <= 1'b1;
                        ubus.u_op  <= op;
                        ubus.u_in1 <= ra_in;
                        ubus.u_in2 <= v_s;
                        ubus.u_dvd <= {ra_in[30], ra_in[29:0], rx_in[29:0]};
                        ubus.u_dvs <= v_s;
                        if (!fvalid_s) begin
                            err     <= 1'b1;
                            done    <= 1'b1;
                            state_r <= WB;
                        end else if ((op == OP_DIV) && (v_s[29:0] == 30'd0)) begin
                            // WB raises done and ovf_set on its first cycle for this path.
                            state_r <= WB;
                        end else begin
                            ubus.u_start <= 1'b1;
                            state_r      <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    ubus.u_start <= 1'b0;
                    case (ubus.u_op)
                        OP_MUL:  cnt_r <= CNT_MUL;
                        OP_DIV:  cnt_r <= CNT_DIV;
                        default: cnt_r <= CNT_ADD;
                    endcase
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (cnt_r == 8'd0) begin
                        done    <= 1'b1;
                        state_r <= WB;
                        case (ubus.u_op)
                            OP_MUL: begin
                                ra_out <= ubus.u_hi;
                                rx_out <= ubus.u_lo;
                                ra_we  <= 1'b1;
                                rx_we  <= 1'b1;
                            end
                            OP_DIV: begin
                                if (ubus.u_ovf) begin
                                    ovf_set <= 1'b1;
                                end else begin
                                    ra_out <= ubus.u_hi;
                                    rx_out <= ubus.u_lo;
                                    ra_we  <= 1'b1;
                                    rx_we  <= 1'b1;
                                end
                            end
                            default: begin
                                ra_out  <= ubus.u_hi;
                                ra_we   <= 1'b1;
                                ovf_set <= ubus.u_ovf;
                            end
                        endcase
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                WB: begin
                    if (done) begin
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        err     <= 1'b0;
                        ovf_set <= 1'b0;
                        ra_we   <= 1'b0;
                        rx_we   <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        done    <= 1'b1;
                        ovf_set <= 1'b1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arith_ctrl.sv
// Self-checking bench for arith_ctrl: behavioural MIX unit model plus a
// reference model of the sequencer's timeline and write-back.
module tb_arith_ctrl;
    localparam int LA = 2;
    localparam int LM = 10;
    localparam int LD = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [1:0]  op;
    logic [5:0]  fspec;
    logic [30:0] mem;
    logic [30:0] ra_in;
    logic [30:0] rx_in;
    logic        busy;
    logic        done;
    logic        err;
    logic        ovf_set;
    logic        ra_we;
    logic        rx_we;
    logic [30:0] ra_out;
    logic [30:0] rx_out;
    int          checks = 0;
    int          errors = 0;

    arith_ctrl_if ubus();

    arith_ctrl #(.LAT_ADD(LA), .LAT_MUL(LM), .LAT_DIV(LD)) dut (
        .clk(clk), .reset(reset), .go(go), .op(op), .fspec(fspec), .mem(mem),
        .ra_in(ra_in), .rx_in(rx_in), .busy(busy), .done(done), .err(err),
        .ovf_set(ovf_set), .ra_we(ra_we), .rx_we(rx_we), .ra_out(ra_out),
        .rx_out(rx_out), .ubus(ubus)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input logic [1:0] o);
        return (o == 2'd2) ? LM : ((o == 2'd3) ? LD : LA);
    endfunction

    // Sign-magnitude unit behaviour: returns {ovf, hi, lo}.
    function automatic logic [62:0] unit_calc(input logic [1:0] o, input logic [30:0] a,
                                              input logic [30:0] v, input logic [60:0] dvd,
                                              input logic [30:0] dvs);
        longint      sa;
        longint      sv;
        longint      s;
        logic [63:0] mag;
        logic [63:0] q;
        logic [63:0] r;
        logic        sg;
        if (o == 2'd2) begin
            mag = {34'd0, a[29:0]} * {34'd0, v[29:0]};
            sg  = a[30] ^ v[30];
            return {1'b0, sg, mag[59:30], sg, mag[29:0]};
        end else if (o == 2'd3) begin
            if (dvs[29:0] == 30'd0) return {1'b1, 62'd0};
            q = {4'd0, dvd[59:0]} / {34'd0, dvs[29:0]};
            r = {4'd0, dvd[59:0]} % {34'd0, dvs[29:0]};
            return {(q >= 64'h4000_0000), dvd[60] ^ dvs[30], q[29:0], dvd[60], r[29:0]};
        end else begin
            sa = a[30] ? -longint'(a[29:0]) : longint'(a[29:0]);
            sv = v[30] ? -longint'(v[29:0]) : longint'(v[29:0]);
            if (o == 2'd1) sv = -sv;
            s   = sa + sv;
            mag = (s < 0) ? 64'(-s) : 64'(s);
            sg  = (s < 0) ? 1'b1 : ((s > 0) ? 1'b0 : a[30]);
            return {(mag >= 64'h4000_0000), sg, mag[29:0], 31'd0};
        end
    endfunction

    // Unit model: latches operands on u_start, result valid only LAT cycles later.
    logic [7:0]  ucnt = 8'd0;
    logic [1:0]  uop_l = 2'd0;
    logic [30:0] ua = 31'd0;
    logic [30:0] uv = 31'd0;
    logic [30:0] udvs = 31'd0;
    logic [60:0] udvd = 61'd0;
    logic [62:0] ures;

    always @(posedge clk) begin
        if (ubus.u_start) begin
            ucnt  <= 8'd1;
            uop_l <= ubus.u_op;
            ua    <= ubus.u_in1;
            uv    <= ubus.u_in2;
            udvd  <= ubus.u_dvd;
            udvs  <= ubus.u_dvs;
        end else if (ucnt != 8'd0 && ucnt != 8'hff) begin
            ucnt <= ucnt + 8'd1;
        end
    end

    always_comb begin
        ures = {1'b1, 31'h2AAA_AAAA, 31'h5555_5555};
        if (int'(ucnt) == lat_of(uop_l)) ures = unit_calc(uop_l, ua, uv, udvd, udvs);
        ubus.u_ovf = ures[62];
        ubus.u_hi  = ures[61:31];
        ubus.u_lo  = ures[30:0];
    end

    function automatic logic ref_valid(input logic [5:0] f);
`ifdef ARITH_CTRL_FIELD_EN
        return (f[5:3] <= f[2:0]) && (f[2:0] <= 3'd5);
`else
        return (f === f);
`endif
    endfunction

    function automatic logic [30:0] ref_v(input logic [30:0] m, input logic [5:0] f);
`ifdef ARITH_CTRL_FIELD_EN
        logic [29:0] mag;
        int          l;
        int          r;
        l   = int'(f[5:3]);
        r   = int'(f[2:0]);
        mag = 30'd0;
        for (int b = 1; b <= 5; b++) begin
            if (b >= ((l == 0) ? 1 : l) && b <= r) mag = {mag[23:0], m[35 - 6 * b -: 6]};
        end
        return {(l == 0) ? m[30] : 1'b0, mag};
`else
        return (f === f) ? m : 31'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_inputs();
        go    = 1'($urandom_range(0, 1));
        op    = 2'($urandom);
        fspec = 6'($urandom);
        mem   = 31'($urandom);
        ra_in = 31'($urandom);
        rx_in = 31'($urandom);
    endtask

    // Issue one go and check every cycle up to and including done.
    task automatic run_op(input logic [1:0] o, input logic [5:0] f, input logic [30:0] m,
                          input logic [30:0] a, input logic [30:0] x);
        logic        valid;
        logic        dz;
        logic        launch;
        logic [30:0] v;
        logic [62:0] res;
        logic        e_raw;
        logic        e_rxw;
        logic        e_ovf;
        int          last;
        valid  = ref_valid(f);
        v      = ref_v(m, f);
        dz     = valid && (o == 2'd3) && (v[29:0] == 30'd0);
        launch = valid && !dz;
        last   = !valid ? 1 : (dz ? 2 : lat_of(o) + 2);
        res    = unit_calc(o, a, v, {a[30], a[29:0], x[29:0]}, v);
        e_raw  = 1'b0;
        e_rxw  = 1'b0;
        e_ovf  = 1'b0;
        if (valid) begin
            if (o == 2'd2) begin
                e_raw = 1'b1;
                e_rxw = 1'b1;
            end else if (o == 2'd3) begin
                e_ovf = res[62];
                e_raw = !res[62];
                e_rxw = !res[62];
            end else begin
                e_raw = 1'b1;
                e_ovf = res[62];
            end
        end
        @(negedge clk);
        go = 1'b1; op = o; fspec = f; mem = m; ra_in = a; rx_in = x;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            chk("busy", 64'(busy), 64'(1));
            chk("done", 64'(done), 64'(k == last));
            chk("u_start", 64'(ubus.u_start), 64'(launch && k == 1));
            chk("err", 64'(err), 64'(!valid && k == 1));
            chk("ra_we", 64'(ra_we), 64'(e_raw && k == last));
            chk("rx_we", 64'(rx_we), 64'(e_rxw && k == last));
            chk("ovf_set", 64'(ovf_set), 64'(e_ovf && k == last));
            if (launch) begin
                chk("u_op", 64'(ubus.u_op), 64'(o));
                chk("u_in1", 64'(ubus.u_in1), 64'(a));
                chk("u_in2", 64'(ubus.u_in2), 64'(v));
                chk("u_dvd", 64'(ubus.u_dvd), 64'({a[30], a[29:0], x[29:0]}));
                chk("u_dvs", 64'(ubus.u_dvs), 64'(v));
            end
            if (k == last && e_raw) chk("ra_out", 64'(ra_out), 64'(res[61:31]));
            if (k == last && e_rxw) chk("rx_out", 64'(rx_out), 64'(res[30:0]));
            randomize_inputs();
        end
        @(negedge clk);
        go = 1'b0;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_done", 64'(done), 64'(0));
        chk("idle_start", 64'(ubus.u_start), 64'(0));
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; op = 2'd0; fspec = 6'd0;
        mem = 31'd0; ra_in = 31'd0; rx_in = 31'd0;
        repeat (3) @(negedge clk);
        chk("rst_outs", 64'({busy, done, err, ovf_set, ra_we, rx_we, ubus.u_start, ubus.u_op}), 64'(0));
        chk("rst_ra_out", 64'(ra_out), 64'(0));
        chk("rst_rx_out", 64'(rx_out), 64'(0));
        chk("rst_in1", 64'(ubus.u_in1), 64'(0));
        chk("rst_in2", 64'(ubus.u_in2), 64'(0));
        chk("rst_dvd", 64'(ubus.u_dvd), 64'(0));
        chk("rst_dvs", 64'(ubus.u_dvs), 64'(0));
        reset = 1'b0;

        run_op(2'd0, 6'd5,  {1'b0, 30'd123}, {1'b0, 30'd123}, 31'd0);
        run_op(2'd1, 6'd13, {1'b1, 30'd123}, {1'b0, 30'd123}, 31'd0);
        run_op(2'd2, 6'd45, {1'b0, 30'o1234567012}, {1'b0, 30'd1000}, 31'd99);
        run_op(2'd3, 6'd5,  {1'b0, 30'd17}, {1'b0, 30'd0}, {1'b0, 30'd50});
        run_op(2'd3, 6'd5,  31'd0, {1'b0, 30'd5}, {1'b0, 30'd7});
        run_op(2'd0, 6'd26, {1'b0, 30'd77}, {1'b0, 30'd9}, 31'd0);
        run_op(2'd0, 6'd5,  {1'b0, 30'h3FFF_FFFF}, {1'b0, 30'h3FFF_FFFF}, 31'd0);
        run_op(2'd3, 6'd5,  {1'b0, 30'd1}, {1'b0, 30'h3FFF_FFFF}, 31'd0);
        run_op(2'd1, 6'd0,  {1'b1, 30'h2345_6789}, {1'b0, 30'd40}, 31'd0);
        run_op(2'd3, 6'd0,  {1'b1, 30'h0123_4567}, {1'b0, 30'd40}, {1'b0, 30'd3});
        run_op(2'd2, 6'd47, {1'b1, 30'h1555_5555}, {1'b1, 30'd3}, 31'd0);

        // Reset during the 5th WAIT cycle of a MUL.
        @(negedge clk);
        go = 1'b1; op = 2'd2; fspec = 6'd5; mem = {1'b0, 30'd3}; ra_in = {1'b0, 30'd4}; rx_in = 31'd0;
        @(negedge clk);
        go = 1'b0;
        chk("mrst_start", 64'(ubus.u_start), 64'(1));
        repeat (5) @(negedge clk);
        chk("mrst_busy_before", 64'(busy), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_in1", 64'(ubus.u_in1), 64'(0));
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("mrst_quiet", 64'({done, ra_we, rx_we, ubus.u_start, ovf_set}), 64'(0));
        end
        run_op(2'd0, 6'd5, {1'b0, 30'd20}, {1'b1, 30'd5}, 31'd0);

        for (int n = 0; n < 40; n++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) :
                {3'($urandom_range(0, 2)), 3'($urandom_range(2, 5))};
            run_op(2'($urandom), f, 31'($urandom), 31'($urandom), 31'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
